// File: rtl/sync_fifo_bram_fwft_if.sv
// FIFO-side handshake bundle for sync_fifo_bram_fwft: write port, FWFT read port,
// occupancy and status flags. The producer/consumer uses master, the FIFO uses slave.
interface sync_fifo_bram_fwft_if #(
    parameter int DATA_WIDTH = 24,
    parameter int SIZE       = 31
);
    localparam int CW = $clog2(SIZE) + 1;

    logic                  flush;
    logic                  fifo_wr_en;
    logic [DATA_WIDTH-1:0] fifo_wr_data;
    logic                  fifo_full_n;
    logic                  fifo_afull;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_empty_n;
    logic                  fifo_aempty;
    logic                  overflow;
    logic                  underflow;
    logic [CW-1:0]         cnt;

    modport master (
        output flush, fifo_wr_en, fifo_wr_data, fifo_rd_en,
        input  fifo_full_n, fifo_afull, fifo_rd_data, fifo_empty_n,
               fifo_aempty, overflow, underflow, cnt
    );

    modport slave (
        input  flush, fifo_wr_en, fifo_wr_data, fifo_rd_en,
        output fifo_full_n, fifo_afull, fifo_rd_data, fifo_empty_n,
               fifo_aempty, overflow, underflow, cnt
    );
endinterface

// File: rtl/sync_fifo_bram_fwft.sv
// FWFT FIFO controller around an external simple-dual-port BRAM (A write, B read),
// with a small register output buffer that hides the configurable BRAM read latency.
module sync_fifo_bram_fwft #(
    parameter int SIZE          = 31,
    parameter int DATA_WIDTH    = 24,
    parameter int ADDR_WIDTH    = $clog2(SIZE),
    parameter int READ_LATENCY  = 1,
    parameter int AFULL_THRESH  = SIZE - 2,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    sync_fifo_bram_fwft_if.slave  f,
    output logic                  bram_clka,
    output logic                  bram_clkb,
    output logic                  bram_rsta,
    output logic                  bram_rstb,
    output logic                  bram_ena,
    output logic                  bram_wea,
    output logic [ADDR_WIDTH-1:0] bram_addra,
    output logic [DATA_WIDTH-1:0] bram_dina,
    output logic                  bram_enb,
    output logic [ADDR_WIDTH-1:0] bram_addrb,
    input  logic [DATA_WIDTH-1:0] bram_doutb,
    input  logic                  bram_rst_busy
);
    localparam int CW  = ADDR_WIDTH + 1;
    localparam int OB  = READ_LATENCY + 1;
    localparam int OBW = $clog2(OB);
    localparam int OW  = $clog2(OB + 2) + 1;

    localparam logic [CW-1:0]         SIZE_C   = CW'(SIZE);
    localparam logic [CW-1:0]         AFULL_C  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0]         AEMPTY_C = CW'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(SIZE - 1);
    localparam logic [OBW-1:0]        OB_LAST  = OBW'(OB - 1);
    localparam logic [OW-1:0]         OB_C     = OW'(OB);

    logic                    ready_q;
    logic [ADDR_WIDTH-1:0]   wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]           cnt_q, cnt_d, bcnt_q, bcnt_d;
    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [DATA_WIDTH-1:0]   obuf_q [OB];
    logic [OBW-1:0]          oh_q, oh_d, ot_q, ot_d;
    logic [OW-1:0]           ocnt_q, ocnt_d;
    logic                    ovf_q, ovf_d, udf_q, udf_d;

    logic                    ready, full_n, empty_n, wr_acc, pop, push, issue, room;
    logic [OW-1:0]           inflight;

    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
        return (p == PTR_LAST) ? '0 : p + ADDR_WIDTH'(1);
    endfunction

    function automatic logic [OBW-1:0] ob_inc(input logic [OBW-1:0] p);
        return (p == OB_LAST) ? '0 : p + OBW'(1);
    endfunction

    assign ready   = ready_q & ~bram_rst_busy;
    assign full_n  = ready & (cnt_q != SIZE_C);
    assign empty_n = (ocnt_q != '0);
    assign wr_acc  = f.fifo_wr_en & full_n;
    assign pop     = f.fifo_rd_en & empty_n;
    assign push    = vld_q[READ_LATENCY-1];

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + OW'(vld_q[i]);
        end
    end

    // A pop in the same cycle frees a slot, which is what keeps the read stream bubble-free.
    assign room  = (ocnt_q + inflight) < (pop ? OB_C + OW'(1) : OB_C);
    assign issue = (bcnt_q != '0) & room & ready & ~f.flush;

    always_comb begin
        wp_d   = wr_acc ? ptr_inc(wp_q) : wp_q;
        rp_d   = issue ? ptr_inc(rp_q) : rp_q;
        vld_d  = (vld_q << 1) | READ_LATENCY'(issue);
        ot_d   = push ? ob_inc(ot_q) : ot_q;
        oh_d   = pop ? ob_inc(oh_q) : oh_q;
        ovf_d  = ovf_q | (f.fifo_wr_en & ~full_n);
        udf_d  = udf_q | (f.fifo_rd_en & ~empty_n);

        case ({wr_acc, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        case ({wr_acc, issue})
            2'b10:   bcnt_d = bcnt_q + CW'(1);
            2'b01:   bcnt_d = bcnt_q - CW'(1);
            default: bcnt_d = bcnt_q;
        endcase
        case ({push, pop})
            2'b10:   ocnt_d = ocnt_q + OW'(1);
            2'b01:   ocnt_d = ocnt_q - OW'(1);
            default: ocnt_d = ocnt_q;
        endcase

        // Flush wins over everything, including a write or a return landing this edge.
        if (f.flush) begin
            wp_d   = '0;
            rp_d   = '0;
            cnt_d  = '0;
            bcnt_d = '0;
            vld_d  = '0;
            ot_d   = '0;
            oh_d   = '0;
            ocnt_d = '0;
            ovf_d  = 1'b0;
            udf_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_q <= 1'b0;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            bcnt_q  <= '0;
            vld_q   <= '0;
            oh_q    <= '0;
            ot_q    <= '0;
            ocnt_q  <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            bcnt_q  <= bcnt_d;
            vld_q   <= vld_d;
            oh_q    <= oh_d;
            ot_q    <= ot_d;
            ocnt_q  <= ocnt_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Data storage needs no reset; occupancy is tracked by the reset pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            obuf_q[ot_q] <= bram_doutb;
        end
    end

    assign f.fifo_full_n  = full_n;
    assign f.fifo_empty_n = empty_n;
    assign f.fifo_rd_data = obuf_q[oh_q];
    assign f.fifo_afull   = (cnt_q >= AFULL_C);
    assign f.fifo_aempty  = (cnt_q <= AEMPTY_C);
    assign f.overflow     = ovf_q;
    assign f.underflow    = udf_q;
    assign f.cnt          = cnt_q;

    assign bram_clka  = clk;
    assign bram_clkb  = clk;
    assign bram_rsta  = ~reset_n;
    assign bram_rstb  = ~reset_n;
    assign bram_ena   = wr_acc;
    assign bram_wea   = wr_acc;
    assign bram_addra = wp_q;
    assign bram_dina  = f.fifo_wr_data;
    assign bram_enb   = issue;
    assign bram_addrb = rp_q;
endmodule

// File: tb/tb_sync_fifo_bram_fwft.sv
// Bench for sync_fifo_bram_fwft: a default instance (READ_LATENCY=1) and a READ_LATENCY=3
// instance, each with a behavioural BRAM and a scoreboard monitor on the pop side.
module tb_sync_fifo_bram_fwft;
    logic clk = 1'b0;
    logic reset_n;
    logic busy;
    always #5 clk = ~clk;

    sync_fifo_bram_fwft_if #(.DATA_WIDTH(24), .SIZE(31)) if0 ();
    sync_fifo_bram_fwft_if #(.DATA_WIDTH(24), .SIZE(31)) if1 ();

    logic        b0_clka, b0_clkb, b0_rsta, b0_rstb, b0_ena, b0_wea, b0_enb;
    logic [4:0]  b0_addra, b0_addrb;
    logic [23:0] b0_dina, b0_doutb;
    logic        b1_clka, b1_clkb, b1_rsta, b1_rstb, b1_ena, b1_wea, b1_enb;
    logic [4:0]  b1_addra, b1_addrb;
    logic [23:0] b1_dina, b1_doutb;

    sync_fifo_bram_fwft u0 (
        .clk(clk), .reset_n(reset_n), .f(if0),
        .bram_clka(b0_clka), .bram_clkb(b0_clkb), .bram_rsta(b0_rsta), .bram_rstb(b0_rstb),
        .bram_ena(b0_ena), .bram_wea(b0_wea), .bram_addra(b0_addra), .bram_dina(b0_dina),
        .bram_enb(b0_enb), .bram_addrb(b0_addrb), .bram_doutb(b0_doutb),
        .bram_rst_busy(busy)
    );

    sync_fifo_bram_fwft #(.READ_LATENCY(3)) u1 (
        .clk(clk), .reset_n(reset_n), .f(if1),
        .bram_clka(b1_clka), .bram_clkb(b1_clkb), .bram_rsta(b1_rsta), .bram_rstb(b1_rstb),
        .bram_ena(b1_ena), .bram_wea(b1_wea), .bram_addra(b1_addra), .bram_dina(b1_dina),
        .bram_enb(b1_enb), .bram_addrb(b1_addrb), .bram_doutb(b1_doutb),
        .bram_rst_busy(busy)
    );

    logic [23:0] mem0 [0:31];
    logic [23:0] mem1 [0:31];
    logic [23:0] p1_0, p1_1, p1_2;

    always @(posedge clk) begin
        if (b0_ena && b0_wea) mem0[b0_addra] <= b0_dina;
        if (b0_enb) b0_doutb <= mem0[b0_addrb];
        if (b1_ena && b1_wea) mem1[b1_addra] <= b1_dina;
        if (b1_enb) p1_0 <= mem1[b1_addrb];
        p1_1 <= p1_0;
        p1_2 <= p1_1;
    end
    assign b1_doutb = p1_2;

    int n_tests = 0;
    int n_fail  = 0;
    int pops1   = 0;
    logic [23:0] exp0[$];
    logic [23:0] exp1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && if0.fifo_rd_en && if0.fifo_empty_n) begin
            if (exp0.size() == 0) chk("sb0_unexpected_pop", 32'(if0.fifo_rd_data), 32'hFFFF_FFFF);
            else chk("sb0_data", 32'(if0.fifo_rd_data), 32'(exp0.pop_front()));
        end
        if (reset_n && if1.fifo_rd_en && if1.fifo_empty_n) begin
            pops1++;
            if (exp1.size() == 0) chk("sb1_unexpected_pop", 32'(if1.fifo_rd_data), 32'hFFFF_FFFF);
            else chk("sb1_data", 32'(if1.fifo_rd_data), 32'(exp1.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [4:0] pa, pb;
    logic       wrap_a, wrap_b;

    task automatic addr_chk();
        chk("addra_range", 32'(b0_addra < 5'd31), 32'd1);
        chk("addrb_range", 32'(b0_addrb < 5'd31), 32'd1);
        if (pa == 5'd30 && b0_addra == 5'd0) wrap_a = 1'b1;
        if (pb == 5'd30 && b0_addrb == 5'd0) wrap_b = 1'b1;
        pa = b0_addra;
        pb = b0_addrb;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, first_c, bubbles, e;
        reset_n = 1'b0;
        busy    = 1'b1;
        {if0.flush, if0.fifo_wr_en, if0.fifo_rd_en} = 3'b000;
        {if1.flush, if1.fifo_wr_en, if1.fifo_rd_en} = 3'b000;
        if0.fifo_wr_data = '0;
        if1.fifo_wr_data = '0;
        pa = '0; pb = '0; wrap_a = 1'b0; wrap_b = 1'b0;

        // Reset and ready gate
        repeat (3) tick();
        chk("rst_full_n", 32'(if0.fifo_full_n), 0);
        chk("rst_empty_n", 32'(if0.fifo_empty_n), 0);
        chk("rst_afull", 32'(if0.fifo_afull), 0);
        chk("rst_aempty", 32'(if0.fifo_aempty), 1);
        chk("rst_cnt", 32'(if0.cnt), 0);
        chk("rst_flags", 32'({if0.overflow, if0.underflow}), 0);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("busy_full_n", 32'(if0.fifo_full_n), 0);
            chk("busy_enb", 32'(b0_enb), 0);
        end
        busy = 1'b0;
        #1;
        chk("ready_full_n", 32'(if0.fifo_full_n), 1);
        chk("ready_cnt", 32'(if0.cnt), 0);
        chk("ready_aempty", 32'(if0.fifo_aempty), 1);

        // Single write, first-word latency
        if0.fifo_wr_en = 1'b1; if0.fifo_wr_data = 24'h000005; exp0.push_back(24'h000005);
        tick();
        if0.fifo_wr_en = 1'b0;
        chk("lat_e0_empty_n", 32'(if0.fifo_empty_n), 0);
        chk("lat_e0_cnt", 32'(if0.cnt), 1);
        tick();
        chk("lat_e1_empty_n", 32'(if0.fifo_empty_n), 0);
        tick();
        chk("lat_e2_empty_n", 32'(if0.fifo_empty_n), 1);
        chk("lat_e2_data", 32'(if0.fifo_rd_data), 32'h5);
        if0.fifo_rd_en = 1'b1;
        tick();
        if0.fifo_rd_en = 1'b0;
        chk("single_pop_cnt", 32'(if0.cnt), 0);
        chk("single_pop_empty_n", 32'(if0.fifo_empty_n), 0);

        // Fill past capacity, drain, underflow
        for (int i = 0; i < 33; i++) begin
            if0.fifo_wr_en = 1'b1; if0.fifo_wr_data = 24'(i);
            if (i < 31) exp0.push_back(24'(i));
            tick();
            e = (i + 1 < 31) ? i + 1 : 31;
            chk("fill_cnt", 32'(if0.cnt), 32'(e));
            chk("fill_full_n", 32'(if0.fifo_full_n), 32'(e != 31));
            chk("fill_afull", 32'(if0.fifo_afull), 32'(e >= 29));
        end
        if0.fifo_wr_en = 1'b0;
        chk("overflow_set", 32'(if0.overflow), 1);
        chk("underflow_clear", 32'(if0.underflow), 0);
        for (int i = 0; i < 31; i++) begin
            chk("drain_empty_n", 32'(if0.fifo_empty_n), 1);
            if0.fifo_rd_en = 1'b1;
            tick();
            chk("drain_cnt", 32'(if0.cnt), 32'(30 - i));
            chk("drain_aempty", 32'(if0.fifo_aempty), 32'(30 - i <= 1));
        end
        if0.fifo_rd_en = 1'b0;
        chk("drained_empty_n", 32'(if0.fifo_empty_n), 0);
        chk("drained_underflow", 32'(if0.underflow), 0);
        if0.fifo_rd_en = 1'b1;
        tick();
        if0.fifo_rd_en = 1'b0;
        chk("underflow_set", 32'(if0.underflow), 1);

        // Pointer wrap over three fill/drain rounds
        pa = b0_addra; pb = b0_addrb;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 31; i++) begin
                if0.fifo_wr_en = 1'b1; if0.fifo_wr_data = 24'(32'h1000 * (r + 1) + i);
                exp0.push_back(24'(32'h1000 * (r + 1) + i));
                tick();
                addr_chk();
            end
            if0.fifo_wr_en = 1'b0;
            chk("wrap_full_n", 32'(if0.fifo_full_n), 0);
            for (int i = 0; i < 31; i++) begin
                if0.fifo_rd_en = 1'b1;
                tick();
                addr_chk();
            end
            if0.fifo_rd_en = 1'b0;
            chk("wrap_empty_n", 32'(if0.fifo_empty_n), 0);
        end
        chk("wrap_a_seen", 32'(wrap_a), 1);
        chk("wrap_b_seen", 32'(wrap_b), 1);

        // Flush with a read in flight
        for (int i = 0; i < 10; i++) begin
            if0.fifo_wr_en = 1'b1; if0.fifo_wr_data = 24'(32'h100 + i);
            exp0.push_back(24'(32'h100 + i));
            tick();
        end
        if0.fifo_wr_en = 1'b0;
        repeat (3) tick();
        chk("preflush_cnt", 32'(if0.cnt), 10);
        chk("preflush_flags", 32'({if0.overflow, if0.underflow}), 32'h3);
        if0.fifo_rd_en = 1'b1;
        #1;
        chk("preflush_issue", 32'(b0_enb), 1);
        tick();
        if0.fifo_rd_en = 1'b0;
        if0.flush = 1'b1;
        if0.fifo_wr_en = 1'b1; if0.fifo_wr_data = 24'h000777;
        tick();
        if0.flush = 1'b0;
        if0.fifo_wr_en = 1'b0;
        exp0.delete();
        chk("flush_cnt", 32'(if0.cnt), 0);
        chk("flush_empty_n", 32'(if0.fifo_empty_n), 0);
        chk("flush_flags", 32'({if0.overflow, if0.underflow}), 0);
        chk("flush_aempty", 32'(if0.fifo_aempty), 1);
        tick();
        chk("flush_drop_empty_n", 32'(if0.fifo_empty_n), 0);
        chk("flush_drop_cnt", 32'(if0.cnt), 0);
        if0.fifo_wr_en = 1'b1; if0.fifo_wr_data = 24'hABCDEF; exp0.push_back(24'hABCDEF);
        tick();
        if0.fifo_wr_en = 1'b0;
        repeat (2) tick();
        chk("postflush_empty_n", 32'(if0.fifo_empty_n), 1);
        chk("postflush_data", 32'(if0.fifo_rd_data), 32'hABCDEF);
        if0.fifo_rd_en = 1'b1;
        tick();
        if0.fifo_rd_en = 1'b0;
        chk("postflush_cnt", 32'(if0.cnt), 0);
        chk("sb0_leftover", 32'(exp0.size()), 0);

        // READ_LATENCY=3 streaming with wr_en and rd_en held high
        first_c = -1;
        bubbles = 0;
        if1.fifo_rd_en = 1'b1;
        for (c = 0; c < 100; c++) begin
            if (c < 40) begin
                if1.fifo_wr_en = 1'b1; if1.fifo_wr_data = 24'(32'h200 + c);
                exp1.push_back(24'(32'h200 + c));
                chk("rl3_full_n", 32'(if1.fifo_full_n), 1);
            end else begin
                if1.fifo_wr_en = 1'b0;
            end
            tick();
            if (first_c < 0 && if1.fifo_empty_n) first_c = c;
            else if (first_c >= 0 && !if1.fifo_empty_n && pops1 < 40) bubbles++;
            if (pops1 == 40) break;
        end
        if1.fifo_rd_en = 1'b0;
        if1.fifo_wr_en = 1'b0;
        chk("rl3_first_valid_edge", 32'(first_c), 4);
        chk("rl3_bubbles", 32'(bubbles), 0);
        chk("rl3_pops", 32'(pops1), 40);
        chk("rl3_leftover", 32'(exp1.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
